async_queue_sink_param: RTL and testbench
=========================================

# async_queue_sink_param

Parametrised dequeue half of a Gray-pointer asynchronous FIFO crossing, generalised from the fixed single-entry TileLink crossing sinks to arbitrary payload width, power-of-two depth and synchroniser depth. It sits in the receiving clock domain. It reads entries from a source-domain-owned memory bus, returns a Gray-coded read pointer to the source, and presents a registered valid/ready dequeue port. It also takes part in the safe-reset handshake so either side can reset independently.

## Interface
- WIDTH, 32, payload bits per entry (>=1)
- DEPTH, 8, entries; power of two, >=2; AW = log2(DEPTH)
- SYNC, 3, synchroniser flop stages for every crossing input (>=2)

- clock  in  1  sink-domain clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- async_mem  in  DEPTH*WIDTH  entry i at bits [i*WIDTH +: WIDTH], written by source, stable while owned by sink
- async_widx  in  AW+1  Gray-coded source write pointer
- async_safe_widx_valid  in  1  source out of reset and pointer meaningful
- async_safe_source_reset_n  in  1  source reset status, low = source in reset
- async_ridx  out  AW+1  Gray-coded read pointer, registered
- async_safe_ridx_valid  out  1  sink out of reset
- async_safe_sink_reset_n  out  1  ~reset, combinational
- deq_valid  out  1  registered dequeue valid
- deq_ready  in  1  consumer accept
- deq_bits  out  WIDTH  registered payload

## Operation
- widx_s = async_widx through SYNC flops, reset 0. src_ok = AND of SYNC-synchronised async_safe_widx_valid and async_safe_source_reset_n, reset 0.
- State: binary read counter rbin[AW:0]. fire = deq_valid & deq_ready. rbin_n = rbin + fire, modulo 2^(AW+1). rgray_n = rbin_n ^ (rbin_n >> 1).
- empty_n = (rgray_n == widx_s).
- Each cycle with src_ok=1:
  - rbin <= rbin_n
  - async_ridx <= rgray_n
  - deq_valid <= !empty_n
  - if !empty_n, deq_bits <= entry rbin_n[AW-1:0]; otherwise deq_bits holds.
- src_ok=0 (source reset or not yet valid) is a synchronous flush: rbin, async_ridx and deq_valid go to 0, deq_bits holds, and async_mem is ignored.
- async_safe_ridx_valid goes to 1 on the first clock edge after reset deasserts.
- The sink never checks for full; the source owns full detection. Pointer wrap is natural AW+1-bit rollover, and the MSB distinguishes lap.
- deq_ready with deq_valid=0 has no effect. deq_bits is stable while deq_valid=1 and deq_ready=0.

## Timing
- Reset values: async_ridx 0, deq_valid 0, deq_bits 0, async_safe_ridx_valid 0, async_safe_sink_reset_n 0, occupancy 0.
- Latency: a widx change reaches widx_s after SYNC edges. deq_valid rises on the next edge, so SYNC+1 cycles from widx change to deq_valid.
- Throughput: one entry per cycle with deq_ready held high and data available. The pointer update is visible on async_ridx on the same edge as the fire.
- Fire on the last available entry: deq_valid falls on the next edge. Fire together with a new widx_s arrival: deq_valid stays high with no bubble.
- Reset mid-operation: everything clears asynchronously and pending entries are lost. The source sees async_safe_sink_reset_n=0 and resets its own side.
- Source reset mid-operation: flush completes within SYNC+1 cycles of async_safe_source_reset_n falling.

## Configuration
- ASYNC_SINK_OCCUPANCY_EN defined: adds output `occupancy out AW+1`, registered as bin(widx_s) − rbin_n modulo 2^(AW+1) using Gray-to-binary conversion. It is 0 while src_ok=0. Range is 0..DEPTH.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=32, DEPTH=8, SYNC=3.
- Reset release, source valid, widx=0 → deq_valid=0, async_ridx=0, async_safe_ridx_valid=1 one cycle after reset deasserts.
- Single write: mem[0]=0xDEADBEEF, widx 0→1 → deq_valid=1 exactly 4 cycles later with deq_bits=0xDEADBEEF; deq_ready=1 → async_ridx=1, deq_valid=0 next cycle.
- Stall: 3 entries pending with deq_ready=0 for 10 cycles → deq_bits and async_ridx held. Then deq_ready=1 → 3 consecutive fires, async_ridx ends at 3 (Gray of 3 = 2'b10 → value 2).
- Wrap: stream 20 entries with widx and the data pattern advancing, deq_ready=1 → all 20 payloads in order, and async_ridx passes through Gray 8 (0b1100) and back to 0 after 16.
- Source reset with 5 pending entries: async_safe_source_reset_n=0 → deq_valid=0 and async_ridx=0 within 4 cycles, and occupancy=0 if ASYNC_SINK_OCCUPANCY_EN is defined.
- With ASYNC_SINK_OCCUPANCY_EN, widx advanced to 8 (full) with no dequeues → occupancy=8. Then 3 fires → occupancy=5.

Source files
------------

// File: rtl/async_queue_sink_param_if.sv
// Crossing bus between the source-domain half of a Gray-pointer async FIFO
// and its sink-domain dequeue half, plus the sink's dequeue port.
// Optional macro ASYNC_SINK_OCCUPANCY_EN adds the occupancy signal.
// master: the sink (drives read pointer, safe-reset status and dequeue outputs).
// slave:  the environment (source memory/pointer and the dequeue consumer).
interface async_queue_sink_param_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH*WIDTH-1:0] async_mem;
  logic [AW:0]            async_widx;
  logic                   async_safe_widx_valid;
  logic                   async_safe_source_reset_n;
  logic [AW:0]            async_ridx;
  logic                   async_safe_ridx_valid;
  logic                   async_safe_sink_reset_n;
  logic                   deq_valid;
  logic                   deq_ready;
  logic [WIDTH-1:0]       deq_bits;
`ifdef ASYNC_SINK_OCCUPANCY_EN
  logic [AW:0]            occupancy;

  modport master (
    input  async_mem, async_widx, async_safe_widx_valid, async_safe_source_reset_n, deq_ready,
    output async_ridx, async_safe_ridx_valid, async_safe_sink_reset_n, deq_valid, deq_bits,
    output occupancy
  );

  modport slave (
    output async_mem, async_widx, async_safe_widx_valid, async_safe_source_reset_n, deq_ready,
    input  async_ridx, async_safe_ridx_valid, async_safe_sink_reset_n, deq_valid, deq_bits,
    input  occupancy
  );
`else
  modport master (
    input  async_mem, async_widx, async_safe_widx_valid, async_safe_source_reset_n, deq_ready,
    output async_ridx, async_safe_ridx_valid, async_safe_sink_reset_n, deq_valid, deq_bits
  );

  modport slave (
    output async_mem, async_widx, async_safe_widx_valid, async_safe_source_reset_n, deq_ready,
    input  async_ridx, async_safe_ridx_valid, async_safe_sink_reset_n, deq_valid, deq_bits
  );
`endif
endinterface

// File: rtl/async_queue_sink_param.sv
// Sink (dequeue) half of a Gray-pointer asynchronous FIFO crossing.
// Synchronises the source write pointer and safe-reset status, keeps a binary
// read counter, returns its Gray form to the source and presents a registered
// valid/ready dequeue port. Any loss of the source (reset or pointer not yet
// valid) flushes the read side synchronously.
// Optional macro ASYNC_SINK_OCCUPANCY_EN adds a registered occupancy output.
module async_queue_sink_param #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int SYNC  = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  async_queue_sink_param_if.master bus
);
  localparam int AW = $clog2(DEPTH);

  logic [SYNC-1:0][AW:0] widx_sync;
  logic [SYNC-1:0]       wvld_sync;
  logic [SYNC-1:0]       srst_sync;
  logic [AW:0]           widx_s;
  logic                  src_ok;

  logic [AW:0]           rbin;
  logic [AW:0]           rbin_n;
  logic [AW:0]           rgray_n;
  logic [AW:0]           ridx_q;
  logic                  fire;
  logic                  empty_n;
  logic                  deq_valid_q;
  logic [WIDTH-1:0]      deq_bits_q;
  logic                  ridx_valid_q;
  logic [WIDTH-1:0]      mem_ent [DEPTH];

  // Slice the flat source memory into addressable entries.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    assign mem_ent[i] = bus.async_mem[i*WIDTH +: WIDTH];
  end

  // ---- stage boundary: crossing inputs -> sink domain (SYNC flops each) ----
  // Shift the write pointer and both source status bits through the synchronisers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      widx_sync <= '0;
      wvld_sync <= '0;
      srst_sync <= '0;
    end else begin
      widx_sync <= {widx_sync[SYNC-2:0], bus.async_widx};
      wvld_sync <= {wvld_sync[SYNC-2:0], bus.async_safe_widx_valid};
      srst_sync <= {srst_sync[SYNC-2:0], bus.async_safe_source_reset_n};
    end
  end

  assign widx_s = widx_sync[SYNC-1];
  assign src_ok = wvld_sync[SYNC-1] & srst_sync[SYNC-1];

  // Next read pointer and emptiness are evaluated against the post-fire pointer,
  // so a fire and a fresh entry on the same edge keep deq_valid high.
  always_comb begin
    fire    = deq_valid_q & bus.deq_ready;
    rbin_n  = rbin + {{AW{1'b0}}, fire};
    rgray_n = rbin_n ^ (rbin_n >> 1);
    empty_n = (rgray_n == widx_s);
  end

  // ---- stage boundary: read pointer, returned Gray pointer, dequeue valid ----
  // Advance the read side while the source is alive; flush it otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rbin        <= '0;
      ridx_q      <= '0;
      deq_valid_q <= 1'b0;
    end else if (src_ok) begin
      rbin        <= rbin_n;
      ridx_q      <= rgray_n;
      deq_valid_q <= !empty_n;
    end else begin
      rbin        <= '0;
      ridx_q      <= '0;
      deq_valid_q <= 1'b0;
    end
  end

  // Load the head entry only when one is available; hold it otherwise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deq_bits_q <= '0;
    end else if (src_ok && !empty_n) begin
      deq_bits_q <= mem_ent[rbin_n[AW-1:0]];
    end
  end

  // Tell the source the sink is out of reset from the first edge after release.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ridx_valid_q <= 1'b0;
    end else begin
      ridx_valid_q <= 1'b1;
    end
  end

  assign bus.async_ridx              = ridx_q;
  assign bus.async_safe_ridx_valid   = ridx_valid_q;
  assign bus.async_safe_sink_reset_n = ~reset;
  assign bus.deq_valid               = deq_valid_q;
  assign bus.deq_bits                = deq_bits_q;

`ifdef ASYNC_SINK_OCCUPANCY_EN
  logic [AW:0] occ_q;

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // Entries still queued after this edge's fire; zero while the source is down.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else if (src_ok) begin
      occ_q <= gray2bin(widx_s) - rbin_n;
    end else begin
      occ_q <= '0;
    end
  end

  assign bus.occupancy = occ_q;
`endif

endmodule

// File: tb/tb_async_queue_sink_param.sv
// Directed bench for async_queue_sink_param (WIDTH=32, DEPTH=8, SYNC=3):
// a vector table for single write / stall / idle-ready, plus hand-written
// sequences for wrap-around streaming, source reset and asynchronous reset.
module tb_async_queue_sink_param;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int SYNC  = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  async_queue_sink_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  async_queue_sink_param #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          rst_first;
    int          widx;
    bit          ready;
    int          cycles;
    bit          exp_valid;
    logic [31:0] exp_bits;
    logic [3:0]  exp_ridx;
  } vec_t;

  vec_t vecs [10];

  function automatic logic [3:0] gray(input int b);
    logic [3:0] x;
    x = b[3:0];
    return x ^ (x >> 1);
  endfunction

  function automatic int gray_to_int(input logic [3:0] gv);
    logic [4:0] b;
    b = '0;
    for (int i = 3; i >= 0; i--) b[i] = b[i+1] ^ gv[i];
    return int'(b);
  endfunction

  function automatic logic [31:0] pat(input int k);
    return 32'h5A00_0000 + 32'(k) * 32'h0001_0101;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_mem(input int i, input logic [31:0] v);
    bus.async_mem[i*WIDTH +: WIDTH] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.async_widx = '0;
    bus.deq_ready = 1'b0;
    bus.async_safe_widx_valid = 1'b1;
    bus.async_safe_source_reset_n = 1'b1;
    step(2);
    reset = 1'b0;
    step(SYNC + 2);
  endtask

  initial begin
    int wbin, nrecv, first_cyc, last_cyc, cyc;
    bit seen12, wrap0;

    //                rst widx rdy cyc  v  bits           ridx
    vecs[0] = '{1'b0, 1, 1'b0, 3,  1'b0, 32'h0,          4'd0};
    vecs[1] = '{1'b0, 1, 1'b0, 1,  1'b1, 32'hDEADBEEF,   4'd0};
    vecs[2] = '{1'b0, 1, 1'b1, 1,  1'b0, 32'hDEADBEEF,   4'd1};
    vecs[3] = '{1'b0, 1, 1'b0, 2,  1'b0, 32'hDEADBEEF,   4'd1};
    vecs[4] = '{1'b1, 3, 1'b0, 4,  1'b1, 32'hDEADBEEF,   4'd0};
    vecs[5] = '{1'b0, 3, 1'b0, 10, 1'b1, 32'hDEADBEEF,   4'd0};
    vecs[6] = '{1'b0, 3, 1'b1, 1,  1'b1, 32'hC0DE0001,   4'd1};
    vecs[7] = '{1'b0, 3, 1'b1, 1,  1'b1, 32'hC0DE0002,   4'd3};
    vecs[8] = '{1'b0, 3, 1'b1, 1,  1'b0, 32'hC0DE0002,   4'd2};
    vecs[9] = '{1'b0, 3, 1'b1, 3,  1'b0, 32'hC0DE0002,   4'd2};

    bus.async_mem = '0;
    bus.async_widx = '0;
    bus.deq_ready = 1'b0;
    bus.async_safe_widx_valid = 1'b1;
    bus.async_safe_source_reset_n = 1'b1;
    set_mem(0, 32'hDEADBEEF);
    for (int i = 1; i < DEPTH; i++) set_mem(i, 32'hC0DE0000 + 32'(i));

    // Reset values.
    step(2);
    chk("rst_ridx", bus.async_ridx, 0);
    chk("rst_valid", bus.deq_valid, 0);
    chk("rst_bits", bus.deq_bits, 0);
    chk("rst_ridx_valid", bus.async_safe_ridx_valid, 0);
    chk("rst_sink_reset_n", bus.async_safe_sink_reset_n, 0);
`ifdef ASYNC_SINK_OCCUPANCY_EN
    chk("rst_occupancy", bus.occupancy, 0);
`endif
    reset = 1'b0;
    #1;
    chk("rel_ridx_valid_before_edge", bus.async_safe_ridx_valid, 0);
    chk("rel_sink_reset_n", bus.async_safe_sink_reset_n, 1);
    @(posedge clock);
    #1;
    chk("rel_ridx_valid", bus.async_safe_ridx_valid, 1);
    chk("rel_valid", bus.deq_valid, 0);
    chk("rel_ridx", bus.async_ridx, 0);
    step(4);

    // Table: single write, stall and consecutive fires, ready while empty.
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].rst_first) do_reset();
      bus.async_widx = gray(vecs[v].widx);
      bus.deq_ready = vecs[v].ready;
      step(vecs[v].cycles);
      chk($sformatf("vec%0d_valid", v), bus.deq_valid, vecs[v].exp_valid);
      chk($sformatf("vec%0d_bits", v), bus.deq_bits, vecs[v].exp_bits);
      chk($sformatf("vec%0d_ridx", v), bus.async_ridx, vecs[v].exp_ridx);
    end
    bus.deq_ready = 1'b0;

    // Wrap: stream 20 entries through the 8-deep ring with ready held high.
    do_reset();
    bus.deq_ready = 1'b1;
    wbin = 0; nrecv = 0; first_cyc = -1; last_cyc = -1; cyc = 0;
    seen12 = 1'b0; wrap0 = 1'b0;
    while (cyc < 200 && !(nrecv == 20 && wbin == 20)) begin
      if (bus.deq_valid) begin
        chk($sformatf("wrap_bits%0d", nrecv), bus.deq_bits, pat(nrecv));
        if (nrecv == 0) first_cyc = cyc;
        last_cyc = cyc;
        nrecv++;
      end
      if (bus.async_ridx == 4'd12) seen12 = 1'b1;
      if (seen12 && bus.async_ridx == 4'd0) wrap0 = 1'b1;
      if (wbin < 20 && ((wbin - gray_to_int(bus.async_ridx)) & 15) < DEPTH) begin
        set_mem(wbin % DEPTH, pat(wbin));
        wbin++;
        bus.async_widx = gray(wbin);
      end
      step(1);
      cyc++;
    end
    chk("wrap_received", nrecv, 20);
    chk("wrap_no_bubble", last_cyc - first_cyc, 19);
    chk("wrap_seen_gray8", seen12, 1);
    chk("wrap_back_to_zero", wrap0, 1);
    chk("wrap_final_ridx", bus.async_ridx, gray(20));
    chk("wrap_final_valid", bus.deq_valid, 0);
    bus.deq_ready = 1'b0;

    // Source reset with 5 pending entries.
    do_reset();
    for (int i = 0; i < 5; i++) set_mem(i, 32'h7700_0000 + 32'(i));
    bus.async_widx = gray(5);
    step(6);
    chk("srcrst_pre_valid", bus.deq_valid, 1);
    chk("srcrst_pre_bits", bus.deq_bits, 32'h7700_0000);
`ifdef ASYNC_SINK_OCCUPANCY_EN
    chk("srcrst_pre_occupancy", bus.occupancy, 5);
`endif
    bus.async_safe_source_reset_n = 1'b0;
    step(SYNC + 1);
    chk("srcrst_valid", bus.deq_valid, 0);
    chk("srcrst_ridx", bus.async_ridx, 0);
    chk("srcrst_bits_held", bus.deq_bits, 32'h7700_0000);
`ifdef ASYNC_SINK_OCCUPANCY_EN
    chk("srcrst_occupancy", bus.occupancy, 0);
`endif

    // Source returns with the same pointer; then sink reset lands mid-cycle.
    bus.async_safe_source_reset_n = 1'b1;
    step(SYNC + 2);
    chk("srcback_valid", bus.deq_valid, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", bus.deq_valid, 0);
    chk("async_rst_bits", bus.deq_bits, 0);
    chk("async_rst_ridx_valid", bus.async_safe_ridx_valid, 0);
    chk("async_rst_sink_reset_n", bus.async_safe_sink_reset_n, 0);

`ifdef ASYNC_SINK_OCCUPANCY_EN
    // Full ring with no dequeues, then three fires.
    do_reset();
    for (int i = 0; i < DEPTH; i++) set_mem(i, pat(i));
    bus.async_widx = gray(8);
    step(6);
    chk("occ_full", bus.occupancy, 8);
    chk("occ_full_bits", bus.deq_bits, pat(0));
    bus.deq_ready = 1'b1;
    step(3);
    bus.deq_ready = 1'b0;
    chk("occ_after3", bus.occupancy, 5);
    chk("occ_after3_ridx", bus.async_ridx, gray(3));
    chk("occ_after3_bits", bus.deq_bits, pat(3));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
